// File: rtl/ram_pkg.sv
// Shared definitions for ram_dp_be: read-mode constants, init FSM states and
// the byte-lane merge used by both the write path and the write-first bypass.
package ram_pkg;

    localparam int unsigned RAM_READ_FIRST  = 32'd0;
    localparam int unsigned RAM_WRITE_FIRST = 32'd1;

    // Widest word the merge helper handles; callers zero-extend into it.
    localparam int unsigned RAM_MAX_DW      = 32'd512;
    localparam int unsigned RAM_MAX_LANE_W  = 32'd9;

    typedef enum logic [0:0] {
        RAM_ST_INIT  = 1'b0,
        RAM_ST_READY = 1'b1
    } ram_init_state_e;

    function automatic logic [RAM_MAX_DW-1:0] ram_byte_merge(
        input logic [RAM_MAX_DW-1:0] old_word,
        input logic [RAM_MAX_DW-1:0] new_word,
        input logic [RAM_MAX_DW-1:0] be,
        input int unsigned           byte_w
    );
        logic [RAM_MAX_DW-1:0]     merged;
        logic [RAM_MAX_LANE_W-1:0] lane;
        merged = '0;
        for (int i = 0; i < RAM_MAX_DW; i++) begin
            lane = RAM_MAX_LANE_W'(32'(i) / byte_w);
            if (be[lane]) begin
                merged[i] = new_word[i];
            end else begin
                merged[i] = old_word[i];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/ram_init_sweep.sv
// Post-reset clear sequencer: walks every address once (INIT), then parks in
// READY. init_busy drops on the same edge READY is entered.
module ram_init_sweep
    import ram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32'd7
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    output logic                  o_init_we,
    output logic [ADDR_WIDTH-1:0] o_init_addr,
    output logic                  o_init_busy
);

    localparam logic [ADDR_WIDTH-1:0] ONE       = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

    ram_init_state_e       r_state;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic                  r_busy;

    // Sweep state, address counter and busy flag.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= RAM_ST_INIT;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
        end else begin
            case (r_state)
                RAM_ST_INIT: begin
                    r_cnt <= r_cnt + ONE;
                    if (r_cnt == LAST_ADDR) begin
                        r_state <= RAM_ST_READY;
                        r_busy  <= 1'b0;
                    end
                end
                RAM_ST_READY: begin
                    r_busy <= 1'b0;
                end
                default: begin
                    r_state <= RAM_ST_INIT;
                    r_cnt   <= '0;
                    r_busy  <= 1'b1;
                end
            endcase
        end
    end

    assign o_init_we   = (r_state == RAM_ST_INIT);
    assign o_init_addr = r_cnt;
    assign o_init_busy = r_busy;

endmodule

// File: rtl/ram_dp_be.sv
// Simple dual-port RAM with byte enables, selectable collision mode and a
// post-reset clear sweep. Define RAM_OUTREG_EN for an extra output stage.
module ram_dp_be
    import ram_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = 32'd32,
    parameter  int unsigned ADDR_WIDTH = 32'd7,
    parameter  int unsigned BYTE_WIDTH = 32'd8,
    parameter  int unsigned READ_MODE  = RAM_READ_FIRST,
    localparam int unsigned NUM_BYTES  = DATA_WIDTH / BYTE_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [NUM_BYTES-1:0]  wbe,
    input  logic [DATA_WIDTH-1:0] d,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] q,
    output logic                  q_valid,
    output logic                  init_busy
);

    localparam int unsigned DEPTH = 32'd1 << ADDR_WIDTH;

    if ((DATA_WIDTH % BYTE_WIDTH) != 32'd0) begin : g_bad_byte_width
        $fatal(1, "ram_dp_be: DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end
    if (DATA_WIDTH > RAM_MAX_DW) begin : g_bad_data_width
        $fatal(1, "ram_dp_be: DATA_WIDTH exceeds RAM_MAX_DW");
    end

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_q;
    logic                  r_q_valid;

    logic                  w_init_we;
    logic [ADDR_WIDTH-1:0] w_init_addr;
    logic                  w_busy;
    logic [DATA_WIDTH-1:0] w_merged;
    logic                  w_mem_we;
    logic [ADDR_WIDTH-1:0] w_mem_addr;
    logic [DATA_WIDTH-1:0] w_mem_wdata;
    logic [DATA_WIDTH-1:0] w_rd_word;

    ram_init_sweep #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_init_sweep (
        .i_clk       (clk),
        .i_rst       (rst),
        .o_init_we   (w_init_we),
        .o_init_addr (w_init_addr),
        .o_init_busy (w_busy)
    );

    assign w_merged = DATA_WIDTH'(ram_byte_merge(RAM_MAX_DW'(r_mem[waddr]),
                                                 RAM_MAX_DW'(d),
                                                 RAM_MAX_DW'(wbe),
                                                 BYTE_WIDTH));

    // The sweep owns the write port while INIT; user writes are dropped.
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_addr  = waddr;
        w_mem_wdata = w_merged;
        if (w_init_we) begin
            w_mem_we    = 1'b1;
            w_mem_addr  = w_init_addr;
            w_mem_wdata = '0;
        end else begin
            w_mem_we    = we;
            w_mem_addr  = waddr;
            w_mem_wdata = w_merged;
        end
    end

    // Same-address bypass for write-first mode.
    always_comb begin
        w_rd_word = r_mem[raddr];
        if ((READ_MODE == RAM_WRITE_FIRST) && we && (waddr == raddr)) begin
            w_rd_word = w_merged;
        end else begin
            w_rd_word = r_mem[raddr];
        end
    end

    // Storage array, not reset; cleared by the sweep instead.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    // Read register and valid strobe; q holds between accepted reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q       <= '0;
            r_q_valid <= 1'b0;
        end else if (!w_busy && re) begin
            r_q       <= w_rd_word;
            r_q_valid <= 1'b1;
        end else begin
            r_q_valid <= 1'b0;
        end
    end

`ifdef RAM_OUTREG_EN
    logic [DATA_WIDTH-1:0] r_q_out;
    logic                  r_q_valid_out;

    // Extra output stage; collision outcome was already fixed at r_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q_out       <= '0;
            r_q_valid_out <= 1'b0;
        end else begin
            r_q_out       <= r_q;
            r_q_valid_out <= r_q_valid;
        end
    end

    assign q       = r_q_out;
    assign q_valid = r_q_valid_out;
`else
    assign q       = r_q;
    assign q_valid = r_q_valid;
`endif

    assign init_busy = w_busy;

endmodule

// File: tb/tb_ram_dp_be.sv
// Directed bench for ram_dp_be: one read-first and one write-first instance
// share the same stimulus; latency follows RAM_OUTREG_EN.
module tb_ram_dp_be;

`ifdef RAM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        we    = 1'b0;
    logic        re    = 1'b0;
    logic [6:0]  waddr = 7'd0;
    logic [6:0]  raddr = 7'd0;
    logic [3:0]  wbe   = 4'h0;
    logic [31:0] d     = 32'h0;
    logic [31:0] q0, q1;
    logic        qv0, qv1, busy0, busy1;
    int          total = 0;
    int          bad   = 0;

    ram_dp_be #(.READ_MODE(32'd0)) u_rf (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wbe(wbe), .d(d),
        .re(re), .raddr(raddr), .q(q0), .q_valid(qv0), .init_busy(busy0)
    );

    ram_dp_be #(.READ_MODE(32'd1)) u_wf (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wbe(wbe), .d(d),
        .re(re), .raddr(raddr), .q(q1), .q_valid(qv1), .init_busy(busy1)
    );

    always #5 clk = ~clk;

    task automatic wr(input logic [6:0] a, input logic [31:0] data, input logic [3:0] be);
        we = 1'b1; waddr = a; d = data; wbe = be;
        @(negedge clk);
        we = 1'b0; wbe = 4'h0;
    endtask

    task automatic rd(input logic [6:0] a, output logic [31:0] r0, output logic [31:0] r1,
                      output logic v0, output logic v1, output logic after0, output logic after1);
        re = 1'b1; raddr = a;
        @(negedge clk);
        re = 1'b0;
        repeat (LAT - 1) @(negedge clk);
        r0 = q0; r1 = q1; v0 = qv0; v1 = qv1;
        @(negedge clk);
        after0 = qv0; after1 = qv1;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (n < 400) begin
            @(negedge clk);
            n++;
            if (busy0 == 1'b0) break;
        end
    endtask

    task automatic test_reset();
        int n;
        logic [31:0] r0, r1;
        logic v0, v1, a0, a1;
        logic [6:0] addrs [3];
        addrs = '{7'd0, 7'd64, 7'd127};
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({q0, q1, qv0, qv1, busy0, busy1} !== {64'h0, 4'b0011}) begin
            bad++;
            $display("FAIL reset_state got q=%h/%h qv=%b%b busy=%b%b want q=0 qv=00 busy=11",
                     q0, q1, qv0, qv1, busy0, busy1);
        end
        rst = 1'b0;
        n = 0;
        while (n < 400) begin
            @(negedge clk);
            n++;
            if (n == 60) begin
                total++;
                if ({q0, qv0, busy0} !== {32'h0, 1'b0, 1'b1}) begin
                    bad++;
                    $display("FAIL init_hold got q=%h qv=%b busy=%b want 0 0 1", q0, qv0, busy0);
                end
            end
            if (busy0 == 1'b0) break;
        end
        total++;
        if (n != 128 || busy1 !== 1'b0) begin
            bad++;
            $display("FAIL sweep_len got %0d cycles busy1=%b want 128 and 0", n, busy1);
        end
        for (int i = 0; i < 3; i++) begin
            rd(addrs[i], r0, r1, v0, v1, a0, a1);
            total++;
            if ({r0, r1, v0, v1, a0, a1} !== {64'h0, 4'b1100}) begin
                bad++;
                $display("FAIL cleared_read addr=%0d got q=%h/%h v=%b%b after=%b%b want 0 v=11 after=00",
                         addrs[i], r0, r1, v0, v1, a0, a1);
            end
        end
    endtask

    task automatic test_byte_enable();
        logic [31:0] r0, r1;
        logic v0, v1, a0, a1;
        wr(7'd5, 32'hDEADBEEF, 4'hF);
        wr(7'd5, 32'h11223344, 4'b0101);
        rd(7'd5, r0, r1, v0, v1, a0, a1);
        total++;
        if ({r0, r1, v0, v1} !== {32'hDE22BE44, 32'hDE22BE44, 2'b11}) begin
            bad++;
            $display("FAIL partial_write got %h/%h v=%b%b want de22be44 v=11", r0, r1, v0, v1);
        end
        wr(7'd5, 32'hFFFFFFFF, 4'h0);
        rd(7'd5, r0, r1, v0, v1, a0, a1);
        total++;
        if ({r0, r1} !== {32'hDE22BE44, 32'hDE22BE44}) begin
            bad++;
            $display("FAIL zero_be_noop got %h/%h want de22be44", r0, r1);
        end
        wr(7'd6, 32'hFFFFFFFF, 4'hF);
        wr(7'd6, 32'h00000000, 4'b1010);
        rd(7'd6, r0, r1, v0, v1, a0, a1);
        total++;
        if ({r0, r1} !== {32'h00FF00FF, 32'h00FF00FF}) begin
            bad++;
            $display("FAIL upper_lanes got %h/%h want 00ff00ff", r0, r1);
        end
    endtask

    task automatic test_collision();
        logic [31:0] r0, r1;
        logic v0, v1, a0, a1;
        wr(7'd9, 32'hAAAAAAAA, 4'hF);
        we = 1'b1; waddr = 7'd9; d = 32'h55555555; wbe = 4'hF; re = 1'b1; raddr = 7'd9;
        @(negedge clk);
        we = 1'b0; re = 1'b0; wbe = 4'h0;
        repeat (LAT - 1) @(negedge clk);
        total++;
        if ({q0, q1, qv0, qv1} !== {32'hAAAAAAAA, 32'h55555555, 2'b11}) begin
            bad++;
            $display("FAIL collision_full got rf=%h wf=%h v=%b%b want aaaaaaaa 55555555 v=11",
                     q0, q1, qv0, qv1);
        end
        rd(7'd9, r0, r1, v0, v1, a0, a1);
        total++;
        if ({r0, r1} !== {32'h55555555, 32'h55555555}) begin
            bad++;
            $display("FAIL after_collision got %h/%h want 55555555", r0, r1);
        end
        we = 1'b1; waddr = 7'd9; d = 32'h12345678; wbe = 4'b0011; re = 1'b1; raddr = 7'd9;
        @(negedge clk);
        we = 1'b0; re = 1'b0; wbe = 4'h0;
        repeat (LAT - 1) @(negedge clk);
        total++;
        if ({q0, q1} !== {32'h55555555, 32'h55555678}) begin
            bad++;
            $display("FAIL collision_partial got rf=%h wf=%h want 55555555 55555678", q0, q1);
        end
        rd(7'd9, r0, r1, v0, v1, a0, a1);
        total++;
        if ({r0, r1} !== {32'h55555678, 32'h55555678}) begin
            bad++;
            $display("FAIL after_partial got %h/%h want 55555678", r0, r1);
        end
    endtask

    task automatic test_independent();
        logic [31:0] r0, r1;
        logic v0, v1, a0, a1;
        we = 1'b1; waddr = 7'd20; d = 32'h0BADC0DE; wbe = 4'hF; re = 1'b1; raddr = 7'd5;
        @(negedge clk);
        we = 1'b0; re = 1'b0; wbe = 4'h0;
        repeat (LAT - 1) @(negedge clk);
        total++;
        if ({q0, q1} !== {32'hDE22BE44, 32'hDE22BE44}) begin
            bad++;
            $display("FAIL indep_read got %h/%h want de22be44", q0, q1);
        end
        rd(7'd20, r0, r1, v0, v1, a0, a1);
        total++;
        if ({r0, r1} !== {32'h0BADC0DE, 32'h0BADC0DE}) begin
            bad++;
            $display("FAIL indep_write got %h/%h want 0badc0de", r0, r1);
        end
    endtask

    task automatic test_back_to_back();
        logic        exp_v;
        logic [31:0] exp_q;
        wr(7'd1, 32'h1, 4'hF);
        wr(7'd2, 32'h2, 4'hF);
        wr(7'd3, 32'h3, 4'hF);
        re = 1'b1; raddr = 7'd1;
        for (int c = 1; c <= LAT + 3; c++) begin
            @(negedge clk);
            if (c < 3) begin
                raddr = raddr + 7'd1;
            end else begin
                re = 1'b0;
            end
            exp_v = (c >= LAT) && (c < LAT + 3);
            exp_q = 32'(c - LAT + 1);
            total++;
            if (qv0 !== exp_v || qv1 !== exp_v || (exp_v && (q0 !== exp_q || q1 !== exp_q))) begin
                bad++;
                $display("FAIL b2b cycle=%0d got q=%h/%h v=%b%b want v=%b q=%h",
                         c, q0, q1, qv0, qv1, exp_v, exp_q);
            end
        end
    endtask

    task automatic test_init_requests();
        int n;
        logic [31:0] r0, r1;
        logic v0, v1, a0, a1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        we = 1'b1; waddr = 7'd3; d = 32'h12345678; wbe = 4'hF; re = 1'b1; raddr = 7'd3;
        @(negedge clk);
        we = 1'b0; re = 1'b0; wbe = 4'h0;
        for (int c = 0; c < 3; c++) begin
            total++;
            if ({qv0, qv1, busy0} !== 3'b001) begin
                bad++;
                $display("FAIL init_ignore cycle=%0d got v=%b%b busy=%b want v=00 busy=1",
                         c, qv0, qv1, busy0);
            end
            @(negedge clk);
        end
        wait_ready(n);
        rd(7'd3, r0, r1, v0, v1, a0, a1);
        total++;
        if ({r0, r1, v0, v1} !== {64'h0, 2'b11}) begin
            bad++;
            $display("FAIL init_write_dropped got %h/%h v=%b%b want 0 v=11", r0, r1, v0, v1);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int n;
        logic [31:0] r0, r1;
        logic v0, v1, a0, a1;
        wr(7'd100, 32'hCAFEF00D, 4'hF);
        rd(7'd100, r0, r1, v0, v1, a0, a1);
        total++;
        if ({r0, r1} !== {32'hCAFEF00D, 32'hCAFEF00D}) begin
            bad++;
            $display("FAIL preload got %h/%h want cafef00d", r0, r1);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (50) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_ready(n);
        total++;
        if (n != 128) begin
            bad++;
            $display("FAIL restart_len got %0d cycles want 128", n);
        end
        rd(7'd100, r0, r1, v0, v1, a0, a1);
        total++;
        if ({r0, r1, v0, v1} !== {64'h0, 2'b11}) begin
            bad++;
            $display("FAIL restart_clear got %h/%h v=%b%b want 0 v=11", r0, r1, v0, v1);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        test_reset();
        test_byte_enable();
        test_collision();
        test_independent();
        test_back_to_back();
        test_init_requests();
        test_reset_mid_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_dp_be.md
# ram_dp_be

Parametrised simple-dual-port synchronous RAM with one write port and one read port, per-byte write enables, a selectable same-address collision mode, a read-valid strobe, and a hardware clear sweep after reset. It is the general-purpose on-chip word store for datapath blocks and register-file-style buffers, replacing fixed-geometry single-port RAMs.

## Interface
- DATA_WIDTH, 32: bits per word; must be an integer multiple of BYTE_WIDTH.
- ADDR_WIDTH, 7: address bits; depth = 2**ADDR_WIDTH words.
- BYTE_WIDTH, 8: bits per write-enable lane; NUM_BYTES = DATA_WIDTH/BYTE_WIDTH.
- READ_MODE, 0: 0 = read-first (old data on collision), 1 = write-first (new merged data on collision).

- clk  input  1  single clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- we  input  1  write request.
- waddr  input  ADDR_WIDTH  write address.
- wbe  input  NUM_BYTES  byte enables; bit i covers d[i*BYTE_WIDTH +: BYTE_WIDTH].
- d  input  DATA_WIDTH  write data.
- re  input  1  read request.
- raddr  input  ADDR_WIDTH  read address.
- q  output  DATA_WIDTH  read data.
- q_valid  output  1  one-cycle strobe: q holds data for an accepted read.
- init_busy  output  1  clear sweep in progress; requests ignored.

## Operation
- Reset (rst high): q = 0, q_valid = 0, init_busy = 1, sweep counter = 0. Array contents are not reset asynchronously.
- Clear sweep: starts on the first clk edge after rst deasserts. FSM states INIT (writes all-zeros to counter address, counter += 1 per cycle) and READY. INIT -> READY after writing address 2**ADDR_WIDTH-1; init_busy falls in the same cycle READY is entered. Sweep takes exactly 2**ADDR_WIDTH cycles.
- rst asserted mid-sweep: counter returns to 0; sweep restarts from address 0 after release.
- In INIT: we and re ignored, q_valid held 0, q held at 0.
- In READY, write: on an edge with we = 1, each byte lane with wbe[i] = 1 takes d's lane; lanes with wbe[i] = 0 keep their value. we = 1 with wbe = 0 is a no-op.
- In READY, read: on an edge with re = 1, word at raddr is registered to q; q_valid = 1 for the following cycle only. re = 0: q holds its previous value, q_valid = 0.
- Collision (we = 1, re = 1, waddr == raddr, same edge): READ_MODE 0 returns pre-write word; READ_MODE 1 returns post-write word (enabled lanes from d, others old).
- Read and write to different addresses are fully independent in the same cycle.

## Timing
- Read latency 1: re sampled at edge N -> q / q_valid valid between edges N and N+1.
- Write visible to a read issued at the next edge (N+1), independent of READ_MODE.
- Back-to-back reads every cycle sustained; q_valid stays high continuously.
- No backpressure; every request in READY is accepted.

## Configuration
- RAM_OUTREG_EN defined: one extra output register stage after the array read. Read latency 2; q_valid delayed identically; q and the extra stage reset to 0; collision semantics unchanged (determined at the array read edge).
- Not defined: latency 1 as above, no extra stage.

## Structure
- Shared package ram_pkg: READ_MODE constants (RAM_READ_FIRST = 0, RAM_WRITE_FIRST = 1), init FSM state enum, and a byte-merge function (old, new, be) -> word used by both write path and write-first bypass.
- One sub-module: ram_init_sweep (INIT/READY FSM, address counter, init_busy); the top muxes its zero-write onto the array write port.
- Elaboration-time check: DATA_WIDTH % BYTE_WIDTH == 0, else fatal.

## Test plan
- Reset then idle with default parameters: init_busy high 128 cycles after rst release, then low; reading addresses 0, 64, 127 returns 0x00000000 with q_valid one cycle after each re.
- Full write 0xDEADBEEF to addr 5, then partial write d = 0x11223344, wbe = 4'b0101 to addr 5; read addr 5 -> 0xDE22BE44.
- Collision at addr 9 holding 0xAAAAAAAA, write 0x55555555 wbe = 4'hF with re same edge: READ_MODE 0 -> q = 0xAAAAAAAA; READ_MODE 1 -> q = 0x55555555; next read -> 0x55555555 in both.
- Requests during sweep: we = 1 addr 3 data 0x12345678 and re = 1 at sweep cycle 10 -> q_valid stays 0; after init_busy falls, read addr 3 -> 0x00000000.
- rst pulsed at sweep cycle 50 after addr 100 was written pre-reset with 0xCAFEF00D: init_busy remains high 128 cycles after the second release; read addr 100 -> 0x00000000.
- RAM_OUTREG_EN defined, reads of addrs 1, 2, 3 on consecutive edges (preloaded 0x1, 0x2, 0x3): q_valid high for three consecutive cycles starting two cycles after the first re, q = 0x1, 0x2, 0x3 in order.
